if_id_stage: RTL

//   IF/ID pipeline boundary between fetch (PC register + instruction ROM) and decode.

---
 rtl/if_id_stage_pkg.sv | 33 +++
 rtl/if_id_stage_slot.sv | 26 ++
 rtl/if_id_stage.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/if_id_stage_pkg.sv
// Shared types and constants for the IF/ID pipeline boundary.
package if_id_stage_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEF  = 32'h0000_3000;
  localparam logic [XLEN-1:0] NOP_INSTR_DEF = 32'h0000_0000;
  localparam int unsigned     IM_DEPTH_DEF  = 1024;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  // One held beat: {fault, PC+4, PC, instruction}, 97 bits.
  typedef struct packed {
    logic            fault;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  // Misaligned or outside [base, base + 4*depth); upper bound kept in 33 bits so it cannot wrap.
  function automatic logic pc_fault(input logic [XLEN-1:0] pc,
                                    input logic [XLEN-1:0] base,
                                    input int unsigned     depth);
    logic [XLEN:0] hi;
    hi = {1'b0, base} + (33'(depth) << 2);
    return (pc[1:0] != 2'b00) | (pc < base) | ({1'b0, pc} >= hi);
  endfunction

endpackage

// File: rtl/if_id_stage_slot.sv
// One entry register of the IF/ID skid buffer with load enable and async reset value.
module if_id_stage_slot
  import if_id_stage_pkg::*;
#(
  parameter entry_t RST_VAL = '0
) (
  input  logic   Clk,
  input  logic   Clr_n,
  input  logic   i_load,
  input  entry_t i_d,
  output entry_t o_q
);

  entry_t r_q;

  always_ff @(posedge Clk or negedge Clr_n) begin
    if (!Clr_n) begin
      r_q <= RST_VAL;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/if_id_stage.sv
// IF/ID boundary: fault check on the fetched PC, 2-entry skid buffer (MAIN/SKID),
// registered in_ready/out_valid and a saturating decode-stall counter.
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
  parameter int unsigned     IM_DEPTH  = IM_DEPTH_DEF,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic            Clk,
  input  logic            Clr_n,
  input  logic [XLEN-1:0] Instr,
  input  logic [XLEN-1:0] PC,
  input  logic [XLEN-1:0] ADD4,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            flush,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [XLEN-1:0] IR_D,
  output logic [XLEN-1:0] PC_D,
  output logic [XLEN-1:0] PC4_D,
  output logic            fault_D,
  output logic [XLEN-1:0] stall_cnt
);

  localparam entry_t RST_ENTRY = '{
    fault: 1'b0,
    pc4:   RESET_PC + 32'd4,
    pc:    RESET_PC,
    instr: NOP_INSTR
  };

  state_e          r_state;
  state_e          w_next_state;
  logic            r_in_ready;
  logic            r_out_valid;
  logic [XLEN-1:0] r_stall_cnt;

  logic   w_accept;
  logic   w_drain;
  logic   w_fault;
  logic   w_main_ld;
  logic   w_main_from_skid;
  logic   w_skid_ld;
  entry_t w_beat;
  entry_t w_main_d;
  entry_t w_main_q;
  entry_t w_skid_q;

  assign w_accept = in_valid & r_in_ready & ~flush;
  assign w_drain  = r_out_valid & out_ready;

  // Faulting fetches carry a NOP but keep their PC/PC+4 for the exception path.
  always_comb begin
    w_fault      = pc_fault(PC, RESET_PC, IM_DEPTH);
    w_beat.fault = w_fault;
    w_beat.pc4   = ADD4;
    w_beat.pc    = PC;
    w_beat.instr = w_fault ? NOP_INSTR : Instr;
  end

  // Next-state and slot load control; flush overrides everything.
  always_comb begin
    w_next_state     = r_state;
    w_main_ld        = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_ld        = 1'b0;
    if (flush) begin
      w_next_state = ST_EMPTY;
    end else begin
      unique case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_main_ld    = 1'b1;
            w_next_state = ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_accept && w_drain) begin
            w_main_ld = 1'b1;
          end else if (w_accept) begin
            w_skid_ld    = 1'b1;
            w_next_state = ST_FULL;
          end else if (w_drain) begin
            w_next_state = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_drain) begin
            w_main_ld        = 1'b1;
            w_main_from_skid = 1'b1;
            w_next_state     = ST_ONE;
          end
        end
        default: w_next_state = ST_EMPTY;
      endcase
    end
  end

  assign w_main_d = w_main_from_skid ? w_skid_q : w_beat;

  always_ff @(posedge Clk or negedge Clr_n) begin
    if (!Clr_n) begin
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_in_ready  <= (w_next_state != ST_FULL);
      r_out_valid <= (w_next_state != ST_EMPTY);
    end
  end

  // Counts edges where decode holds off a live beat; sticks at all-ones.
  always_ff @(posedge Clk or negedge Clr_n) begin
    if (!Clr_n) begin
      r_stall_cnt <= '0;
    end else if (r_out_valid && !out_ready && !flush && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  if_id_stage_slot #(.RST_VAL(RST_ENTRY)) u_main (
    .Clk    (Clk),
    .Clr_n  (Clr_n),
    .i_load (w_main_ld),
    .i_d    (w_main_d),
    .o_q    (w_main_q)
  );

  if_id_stage_slot #(.RST_VAL(RST_ENTRY)) u_skid (
    .Clk    (Clk),
    .Clr_n  (Clr_n),
    .i_load (w_skid_ld),
    .i_d    (w_beat),
    .o_q    (w_skid_q)
  );

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign IR_D      = w_main_q.instr;
  assign PC_D      = w_main_q.pc;
  assign PC4_D     = w_main_q.pc4;
  assign fault_D   = w_main_q.fault;
  assign stall_cnt = r_stall_cnt;

endmodule
